// File: rtl/sseg_scan_dimmer_if.sv
// Bundle of display-side signals for sseg_scan_dimmer.
// The master drives digits, decimal points and brightness; the slave (the
// scanner) drives the anode/segment lines and the frame snapshot pulse.
interface sseg_scan_dimmer_if #(
  parameter int PWM_W = 4
);
  logic [3:0]       d0;
  logic [3:0]       d1;
  logic [3:0]       d2;
  logic [3:0]       d3;
  logic [3:0]       dp;
  logic [PWM_W-1:0] duty;
  logic [3:0]       an;
  logic [7:0]       sseg;
  logic             frame_tick;

  modport master (
    output d0, d1, d2, d3, dp, duty,
    input  an, sseg, frame_tick
  );

  modport slave (
    input  d0, d1, d2, d3, dp, duty,
    output an, sseg, frame_tick
  );
endinterface

// File: rtl/sseg_scan_dimmer.sv
// Time-multiplexed 4-digit common-anode seven-segment driver with PWM dimming.
// Digits and decimal points are snapshotted once per frame (on the 3->0 scan
// wrap) so a frame never mixes old and new values. Each digit slot starts with
// a short blanking window to stop ghosting between digits.
// Optional feature: define LZ_BLANK_EN to blank leading zeros (digits 3..1)
// based on the snapshotted values; digit 0 is always shown.
module sseg_scan_dimmer #(
  parameter int REFRESH_DIV = 12500,
  parameter int GUARD       = 16,
  parameter int PWM_W       = 4
) (
  input  logic                clk,
  input  logic                rst,
  sseg_scan_dimmer_if.slave   bus
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [CNT_W-1:0] refresh_cnt;
  logic [CNT_W-1:0] refresh_nxt;
  logic [1:0]       scan_idx;
  logic [1:0]       scan_nxt;
  logic [PWM_W-1:0] pwm_cnt;
  logic [3:0][3:0]  shadow;
  logic [3:0]       dp_sh;
  logic [3:0]       blank;
  logic             slot_end;
  logic             frame_end;
  logic             pwm_on;
  logic             slot_en;
  logic [3:0]       an_nxt;
  logic [7:0]       sseg_nxt;
  logic [3:0]       an_q;
  logic [7:0]       sseg_q;
  logic             frame_tick_q;

  // Hex value to active-low g..a segment pattern.
  function automatic logic [6:0] hex7seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

`ifdef LZ_BLANK_EN
  // Leading-zero mask from the snapshot; a lit decimal point keeps its digit visible.
  always_comb begin
    blank    = 4'b0000;
    blank[3] = (shadow[3] == 4'h0) && !dp_sh[3];
    blank[2] = (shadow[3] == 4'h0) && (shadow[2] == 4'h0) && !dp_sh[2];
    blank[1] = (shadow[3] == 4'h0) && (shadow[2] == 4'h0) &&
               (shadow[1] == 4'h0) && !dp_sh[1];
  end
`else
  assign blank = 4'b0000;
`endif

  // Next counter state and the drive pattern for the upcoming cycle.
  always_comb begin
    slot_end    = (refresh_cnt == CNT_W'(REFRESH_DIV - 1));
    frame_end   = slot_end && (scan_idx == 2'd3);
    refresh_nxt = slot_end ? '0 : refresh_cnt + 1'b1;
    scan_nxt    = slot_end ? scan_idx + 2'd1 : scan_idx;
    pwm_on      = (bus.duty == '1) || (pwm_cnt < bus.duty);
    slot_en     = (refresh_cnt >= CNT_W'(GUARD)) && pwm_on && !blank[scan_idx];
    an_nxt      = 4'b1111;
    sseg_nxt    = 8'hFF;
    if (slot_en) begin
      an_nxt   = ~(4'b0001 << scan_idx);
      sseg_nxt = {~dp_sh[scan_idx], hex7seg(shadow[scan_idx])};
    end
  end

  // Counters, frame snapshot and registered display outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_cnt  <= '0;
      scan_idx     <= 2'd0;
      pwm_cnt      <= '0;
      shadow       <= '0;
      dp_sh        <= 4'b0000;
      an_q         <= 4'b1111;
      sseg_q       <= 8'hFF;
      frame_tick_q <= 1'b0;
    end else begin
      refresh_cnt  <= refresh_nxt;
      scan_idx     <= scan_nxt;
      pwm_cnt      <= pwm_cnt + 1'b1;
      an_q         <= an_nxt;
      sseg_q       <= sseg_nxt;
      frame_tick_q <= frame_end;
      if (frame_end) begin
        shadow <= {bus.d3, bus.d2, bus.d1, bus.d0};
        dp_sh  <= bus.dp;
      end
    end
  end

  assign bus.an         = an_q;
  assign bus.sseg       = sseg_q;
  assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_sseg_scan_dimmer.sv
// Self-checking bench for sseg_scan_dimmer with a small behavioural model.
// The model derives the expected display from the elapsed cycle count since
// reset: slot position, digit index and PWM phase are plain divisions/modulos.
module tb_sseg_scan_dimmer;

  localparam int REFRESH_DIV = 8;
  localparam int GUARD       = 2;
  localparam int PWM_W       = 4;
  localparam int FRAME       = 4 * REFRESH_DIV;

  localparam logic [6:0] HEX [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  // Model state: cycles since reset release and the snapshot the display uses.
  int         k;
  logic [3:0] m_sh [4];
  logic [3:0] m_dp;

  sseg_scan_dimmer_if #(.PWM_W(PWM_W)) bus ();

  sseg_scan_dimmer #(
    .REFRESH_DIV(REFRESH_DIV),
    .GUARD      (GUARD),
    .PWM_W      (PWM_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at k=%0d: got %0h, want %0h", tag, k, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] a3, input logic [3:0] a2,
                               input logic [3:0] a1, input logic [3:0] a0,
                               input logic [3:0] dp, input logic [3:0] duty);
    bus.d3   = a3;
    bus.d2   = a2;
    bus.d1   = a1;
    bus.d0   = a0;
    bus.dp   = dp;
    bus.duty = duty;
  endtask

  function automatic bit modelBlanked(input int idx);
    bit b;
    b = 1'b0;
`ifdef LZ_BLANK_EN
    if (idx > 0 && m_dp[idx] == 1'b0) begin
      b = 1'b1;
      for (int j = idx; j < 4; j++)
        if (m_sh[j] != 4'h0) b = 1'b0;
    end
`endif
    return b;
  endfunction

  // One clock: capture applied inputs, advance the model, compare outputs.
  task automatic stepCycle();
    logic       r_in;
    logic [3:0] din [4];
    logic [3:0] dp_in;
    int         duty_in;
    int         r, idx, p;
    bit         en;
    logic [3:0] exp_an;
    logic [7:0] exp_sseg;
    logic       exp_ft;
    r_in    = rst;
    din[0]  = bus.d0;
    din[1]  = bus.d1;
    din[2]  = bus.d2;
    din[3]  = bus.d3;
    dp_in   = bus.dp;
    duty_in = int'(bus.duty);
    @(posedge clk);
    #1;
    exp_an   = 4'b1111;
    exp_sseg = 8'hFF;
    exp_ft   = 1'b0;
    if (r_in) begin
      k = 0;
      for (int i = 0; i < 4; i++) m_sh[i] = 4'h0;
      m_dp = 4'h0;
    end else begin
      k++;
      r   = (k - 1) % REFRESH_DIV;
      idx = ((k - 1) / REFRESH_DIV) % 4;
      p   = (k - 1) % (1 << PWM_W);
      en  = (r >= GUARD) && ((duty_in == (1 << PWM_W) - 1) || (p < duty_in))
            && !modelBlanked(idx);
      if (en) begin
        exp_an   = 4'b1111;
        exp_an[idx] = 1'b0;
        exp_sseg = {~m_dp[idx], HEX[m_sh[idx]]};
      end
      if (k % FRAME == 0) begin
        exp_ft = 1'b1;
        for (int i = 0; i < 4; i++) m_sh[i] = din[i];
        m_dp = dp_in;
      end
    end
    checkOutput("an", 32'(bus.an), 32'(exp_an));
    checkOutput("sseg", 32'(bus.sseg), 32'(exp_sseg));
    checkOutput("frame_tick", 32'(bus.frame_tick), 32'(exp_ft));
    checkOutput("an_single_low", 32'($countones(~bus.an) <= 1), 32'(1));
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) stepCycle();
  endtask

  // Directed scenarios followed by randomized traffic and random resets.
  initial begin
    checks = 0;
    errors = 0;
    k      = 0;
    m_dp   = 4'h0;
    for (int i = 0; i < 4; i++) m_sh[i] = 4'h0;

    rst = 1'b1;
    applyStimulus(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'd15);
    runCycles(3);
    rst = 1'b0;

    applyStimulus(4'h1, 4'h2, 4'h3, 4'h5, 4'h0, 4'd15);
    runCycles(2 * FRAME + 12);
    applyStimulus(4'h1, 4'h2, 4'h3, 4'h9, 4'h0, 4'd15);
    runCycles(2 * FRAME);

    applyStimulus(4'h1, 4'h2, 4'h3, 4'h9, 4'h0, 4'd0);
    runCycles(2 * FRAME);
    applyStimulus(4'h1, 4'h2, 4'h3, 4'h9, 4'h0, 4'd8);
    runCycles(2 * FRAME);

    applyStimulus(4'h0, 4'h0, 4'h0, 4'h7, 4'h0, 4'd15);
    runCycles(3 * FRAME);
    applyStimulus(4'h0, 4'h0, 4'h0, 4'h7, 4'b0100, 4'd15);
    runCycles(3 * FRAME);

    runCycles(2 * REFRESH_DIV + 3);
    rst = 1'b1;
    runCycles(2);
    rst = 1'b0;
    applyStimulus(4'hA, 4'hB, 4'hC, 4'hD, 4'b1010, 4'd15);
    runCycles(2 * FRAME);

    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 1) == 0)
          applyStimulus(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                        4'($urandom), bus.duty);
        else
          applyStimulus(4'h0, 4'($urandom_range(0, 1)), 4'($urandom_range(0, 1)),
                        4'($urandom), 4'($urandom), bus.duty);
      end
      if ($urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 3))
          0:       bus.duty = 4'd0;
          1:       bus.duty = 4'd15;
          default: bus.duty = 4'($urandom);
        endcase
      end
      rst = ($urandom_range(0, 299) == 0);
      stepCycle();
    end
    rst = 1'b0;
    runCycles(FRAME);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
